// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU: function codes, sequencer states
// and code-classification helpers used by both the slice and the sequencer.
package alu_pkg;

   localparam int DEF_WIDTH = 32;

   localparam logic [5:0] FN_AND = 6'd36;
   localparam logic [5:0] FN_OR  = 6'd37;
   localparam logic [5:0] FN_ADD = 6'd32;
   localparam logic [5:0] FN_SUB = 6'd34;
   localparam logic [5:0] FN_SLT = 6'd42;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // SUB and SLT both compute A + ~B + 1.
   function automatic logic is_sub(input logic [5:0] code);
      return (code == FN_SUB) || (code == FN_SLT);
   endfunction

   function automatic logic is_logic(input logic [5:0] code);
      return (code == FN_AND) || (code == FN_OR);
   endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational single-bit ALU cell: AND / OR / add / subtract with carry,
// plus the raw sum bit exported as 'set' for SLT at the MSB.
module alu_bit_slice
   import alu_pkg::*;
(
   input  logic       a,
   input  logic       b,
   input  logic       carry_in,
   input  logic [5:0] code,
   output logic       out,
   output logic       carry_out,
   output logic       set
);

   logic bb;
   logic sum;

   assign bb        = b ^ is_sub(code);
   assign sum       = a ^ bb ^ carry_in;
   assign carry_out = (a & bb) | (a & carry_in) | (bb & carry_in);
   assign set       = sum;

   // SLT writes zeros everywhere; the sequencer patches bit 0 with 'set'.
   always_comb begin
      out = sum;
      case (code)
         FN_AND:  out = a & b;
         FN_OR:   out = a | b;
         FN_SLT:  out = 1'b0;
         default: out = sum;
      endcase
   end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial execution stage: walks one alu_bit_slice across WIDTH bits with a
// registered carry. Optional signed-overflow output under ALU_OVERFLOW_EN.
module serial_alu_sequencer
   import alu_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [5:0]       signal_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             carry_out
`ifdef ALU_OVERFLOW_EN
   ,
   output logic             overflow
`endif
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

   state_t           st, st_nx;
   logic [WIDTH-1:0] a_q, b_q, res_q;
   logic [5:0]       code_q;
   logic [IW-1:0]    idx;
   logic             cq;
   logic             cflag;
   logic             rdy_q;
   logic             last;
   logic             s_out, s_cout, s_set;

   alu_bit_slice u_slice (
      .a         (a_q[idx]),
      .b         (b_q[idx]),
      .carry_in  (cq),
      .code      (code_q),
      .out       (s_out),
      .carry_out (s_cout),
      .set       (s_set)
   );

   assign last      = (idx == LAST);
   // rdy_q keeps in_ready low while held in reset, even though state is IDLE.
   assign in_ready  = (st == IDLE) && rdy_q;
   assign out_valid = (st == DONE);
   assign result    = res_q;
   assign zero      = (res_q == '0);
   assign carry_out = cflag;

   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (in_valid && in_ready) st_nx = RUN;
         RUN:     if (last) st_nx = DONE;
         DONE:    if (out_ready) st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= IDLE;
      end else begin
         st <= st_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q  <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         code_q <= FN_ADD;
         idx    <= '0;
         cq     <= 1'b0;
         res_q  <= '0;
         cflag  <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         case (st)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_q    <= op_a;
                  b_q    <= op_b;
                  code_q <= signal_in;
                  idx    <= '0;
                  cq     <= is_sub(signal_in);
               end
            end
            RUN: begin
               res_q[idx] <= s_out;
               cq         <= s_cout;
               if (!last) begin
                  idx <= idx + IW'(1);
               end else begin
                  cflag <= is_logic(code_q) ? 1'b0 : s_cout;
                  if (code_q == FN_SLT) res_q[0] <= s_set;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef ALU_OVERFLOW_EN
   logic ovf_q;

   assign overflow = ovf_q;

   // Overflow is the carry into the MSB xor the carry out of it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (st == RUN && last) begin
         ovf_q <= (is_logic(code_q) || code_q == FN_SLT) ? 1'b0 : (cq ^ s_cout);
      end
   end
`endif

endmodule
